// File: rtl/booth_mult_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : booth_mult_arbiter
// Brief   : Radix-2 sequential Booth multiplier shared by two round-robin
//           requesters; one Booth step per clock, tagged signed product.
// Rev     : 1.0
// ---------------------------------------------------------------------------
module booth_mult_arbiter #(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req0,
  input  logic [N-1:0]   a0,
  input  logic [N-1:0]   b0,
  input  logic           req1,
  input  logic [N-1:0]   a1,
  input  logic [N-1:0]   b1,
  output logic           ack0,
  output logic           ack1,
  output logic           busy,
  output logic           done,
  output logic           owner,
  output logic [2*N-1:0] result
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_run  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;
  localparam int         c_cw   = $clog2(N);

  logic [1:0]      r_state, w_state_nxt;
  logic [N:0]      r_a, r_m;
  logic [N-1:0]    r_q;
  logic            r_qm1;
  logic [c_cw-1:0] r_cnt;
  logic            r_last, r_owner_nxt;

  logic            w_gnt_vld, w_gnt_id, w_last_step;
  logic [N:0]      w_sum, w_a_nxt;
  logic [N-1:0]    w_q_nxt;

  // Tie goes to whichever requester was not served last.
  assign w_gnt_vld   = req0 | req1;
  assign w_gnt_id    = (req0 & req1) ? ~r_last : req1;
  assign w_last_step = (r_cnt == c_cw'(N - 1));

  always_comb begin
    w_sum = r_a;
    case ({r_q[0], r_qm1})
      2'b01:   w_sum = r_a + r_m;
      2'b10:   w_sum = r_a - r_m;
      default: w_sum = r_a;
    endcase
  end

  // Arithmetic right shift of {A,Q,QM1}; QM1 picks up the old Q[0].
  assign w_a_nxt = {w_sum[N], w_sum[N:1]};
  assign w_q_nxt = {w_sum[0], r_q[N-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= c_idle;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_gnt_vld)   w_state_nxt = c_run;
      c_run:   if (w_last_step) w_state_nxt = c_done;
      c_done:  w_state_nxt = c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  // Acks are gated by rst so the outputs read zero while reset is held.
  always_comb begin
    ack0 = (r_state == c_idle) && !rst && w_gnt_vld && !w_gnt_id;
    ack1 = (r_state == c_idle) && !rst && w_gnt_vld &&  w_gnt_id;
    busy = (r_state != c_idle);
    done = (r_state == c_done);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_m         <= '0;
      r_q         <= '0;
      r_qm1       <= 1'b0;
      r_cnt       <= '0;
      r_last      <= 1'b1;
      r_owner_nxt <= 1'b0;
      owner       <= 1'b0;
      result      <= '0;
    end else begin
      case (r_state)
        c_idle: begin
          if (w_gnt_vld) begin
            r_a         <= '0;
            r_q         <= w_gnt_id ? a1 : a0;
            r_m         <= w_gnt_id ? {b1[N-1], b1} : {b0[N-1], b0};
            r_qm1       <= 1'b0;
            r_cnt       <= '0;
            r_owner_nxt <= w_gnt_id;
            r_last      <= w_gnt_id;
          end
        end
        c_run: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_qm1 <= r_q[0];
          r_cnt <= r_cnt + c_cw'(1);
          if (w_last_step) begin
            result <= {w_a_nxt[N-1:0], w_q_nxt};
            owner  <= r_owner_nxt;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_booth_mult_arbiter.sv
`default_nettype none
// Bench for booth_mult_arbiter: a cycle-level behavioural model (grant rules,
// fixed latency, arithmetic product) compared every cycle, plus literal pins.
module tb_booth_mult_arbiter;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           req0, req1;
  logic [N-1:0]   a0, b0, a1, b1;
  logic           ack0, ack1, busy, done, owner;
  logic [2*N-1:0] result;

  int checks = 0;
  int errors = 0;

  booth_mult_arbiter #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .ack0(ack0), .ack1(ack1), .busy(busy), .done(done),
    .owner(owner), .result(result)
  );

  always #5 clk = ~clk;

  // Model: a job occupies N+1 cycles after its grant; the last one is done.
  logic           m_last, m_pown, m_own;
  int             m_timer;
  logic [2*N-1:0] m_pend, m_res;
  logic           e_g0, e_g1;

  always_comb begin
    e_g0 = 1'b0;
    e_g1 = 1'b0;
    if (!rst && m_timer == 0) begin
      if (req0 && (!req1 || m_last)) e_g0 = 1'b1;
      else if (req1)                 e_g1 = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_last  <= 1'b1;
      m_timer <= 0;
      m_pend  <= '0;
      m_pown  <= 1'b0;
      m_res   <= '0;
      m_own   <= 1'b0;
    end else if (m_timer == 0) begin
      if (e_g0 || e_g1) begin
        m_timer <= N + 1;
        m_pend  <= e_g1 ? $signed(a1) * $signed(b1) : $signed(a0) * $signed(b0);
        m_pown  <= e_g1;
        m_last  <= e_g1;
      end
    end else begin
      m_timer <= m_timer - 1;
      if (m_timer == 2) begin
        m_res <= m_pend;
        m_own <= m_pown;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic compare();
    chk("ack0",   64'(ack0),   64'(e_g0));
    chk("ack1",   64'(ack1),   64'(e_g1));
    chk("busy",   64'(busy),   64'(m_timer != 0));
    chk("done",   64'(done),   64'(m_timer == 1));
    chk("owner",  64'(owner),  64'(m_own));
    chk("result", 64'(result), 64'(m_res));
  endtask

  task automatic cyc();
    @(negedge clk); compare();
    @(posedge clk); #1;
  endtask

  // Counts cycles after the grant edge until done is seen (cycle 1 = first RUN).
  task automatic wait_done(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk); compare();
      if (done) n = i;
      @(posedge clk); #1;
      if (n > 0) break;
    end
    if (n < 0) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic op(input bit id, input logic [N-1:0] a, input logic [N-1:0] b,
                    input logic [2*N-1:0] exp);
    int n;
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    @(negedge clk); compare();
    chk("op_ack", 64'(id ? ack1 : ack0), 64'(1));
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = ~a0; b0 = ~b0; a1 = ~a1; b1 = ~b1;
    wait_done(n);
    chk("op_latency", 64'(n), 64'(N + 1));
    chk("op_result",  64'(result), 64'(exp));
    chk("op_owner",   64'(owner),  64'(id));
  endtask

  initial begin
    int ng, n;
    int gt[4];
    bit gid[4];
    int p;
    logic [N-1:0] va, vb;

    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) cyc();
    @(negedge clk); compare();
    chk("rst_busy",   64'(busy),   64'(0));
    chk("rst_result", 64'(result), 64'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc();

    op(1'b0, 4'd3, 4'd2, 8'h06);
    op(1'b1, 4'hE, 4'd5, 8'hF6);
    op(1'b1, 4'h8, 4'h8, 8'h40);

    // Both requesters held from reset: strict alternation, one grant per 6 cycles.
    rst = 1'b1;
    cyc();
    req0 = 1'b1; a0 = 4'd5; b0 = 4'hD;
    req1 = 1'b1; a1 = 4'd7; b1 = 4'd7;
    cyc();
    rst = 1'b0;
    ng = 0;
    for (int i = 0; i < 40 && ng < 4; i++) begin
      @(negedge clk); compare();
      if (ack0 || ack1) begin
        gt[ng] = i; gid[ng] = ack1; ng++;
      end
      @(posedge clk); #1;
    end
    req0 = 1'b0; req1 = 1'b0;
    chk("rr_count", 64'(ng), 64'(4));
    for (int j = 0; j < 4; j++) begin
      chk("rr_id", 64'(gid[j]), 64'(j % 2));
      if (j > 0) chk("rr_spacing", 64'(gt[j] - gt[j-1]), 64'(6));
    end
    wait_done(n);
    chk("rr_last_result", 64'(result), 64'(8'h31));
    cyc();

    // Request arriving while busy waits for the first IDLE cycle.
    req0 = 1'b1; a0 = 4'd1; b0 = 4'd1;
    cyc();
    req0 = 1'b0;
    req1 = 1'b1; a1 = 4'd2; b1 = 4'd3;
    n = -1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk); compare();
      if (ack1) n = i;
      @(posedge clk); #1;
      if (n > 0) break;
    end
    req1 = 1'b0;
    chk("busy_ack1_cycle", 64'(n), 64'(N + 2));
    wait_done(n);
    chk("busy_result", 64'(result), 64'(8'h06));
    chk("busy_owner",  64'(owner),  64'(1));
    cyc();

    // Reset on the second RUN cycle aborts the job.
    req0 = 1'b1; a0 = 4'd3; b0 = 4'd3;
    cyc();
    req0 = 1'b0;
    cyc();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    @(negedge clk); compare();
    chk("abort_busy",   64'(busy),   64'(0));
    chk("abort_result", 64'(result), 64'(0));
    chk("abort_owner",  64'(owner),  64'(0));
    chk("abort_ack0",   64'(ack0),   64'(0));
    @(posedge clk); #1;
    cyc();
    rst = 1'b0;
    @(negedge clk); compare();
    chk("abort_tie_ack0", 64'(ack0), 64'(1));
    @(posedge clk); #1;
    req0 = 1'b0; req1 = 1'b0;
    wait_done(n);
    chk("abort_next_result", 64'(result), 64'(8'h09));
    cyc();

    // Exhaustive sweep through requester 0.
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        va = N'(a); vb = N'(b);
        p = $signed(va) * $signed(vb);
        op(1'b0, va, vb, p[2*N-1:0]);
      end
    end
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
